// File: rtl/frame_scanout.sv
// frame_scanout: VGA timing generator and upscaling reader for the 128x64x12 frame memory.
// Counters feed a fixed 3-stage pipeline (decode/address, memory read, output register)
// so rgb, syncs, de and frame_start leave the block mutually aligned.
module frame_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned WIN_X0      = 64,
  parameter int unsigned WIN_Y0      = 112
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] border_rgb,
  output logic [6:0]  rd_col_addr,
  output logic [5:0]  rd_row_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned MEM_COLS = 128;
  localparam int unsigned MEM_ROWS = 64;
  localparam int unsigned WIN_X1   = WIN_X0 + (MEM_COLS << SCALE_SHIFT);
  localparam int unsigned WIN_Y1   = WIN_Y0 + (MEM_ROWS << SCALE_SHIFT);
  localparam int unsigned COL_W    = 7;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned RGB_W    = 12;

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;

  logic [31:0]      hc_c;
  logic [31:0]      vc_c;
  logic             active_c;
  logic             in_win_c;
  logic             hs_c;
  logic             vs_c;
  logic             fs_c;
  logic [COL_W-1:0] col_c;
  logic [ROW_W-1:0] row_c;

  logic             s1_active, s1_in_win, s1_hs, s1_vs, s1_fs;
  logic             s2_active, s2_in_win, s2_hs, s2_vs, s2_fs;
  logic [RGB_W-1:0] px_c;

  // Raster counters; en low parks the scan at the frame origin
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      if (v_cnt == VW'(V_TOTAL - 1)) v_cnt <= '0;
      else                           v_cnt <= v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Decode the current raster position into flags and window-relative memory addresses
  always_comb begin
    hc_c     = 32'(h_cnt);
    vc_c     = 32'(v_cnt);
    active_c = (hc_c < H_ACTIVE) && (vc_c < V_ACTIVE);
    in_win_c = active_c && (hc_c >= WIN_X0) && (hc_c < WIN_X1)
                        && (vc_c >= WIN_Y0) && (vc_c < WIN_Y1);
    hs_c     = !((hc_c >= HS_START) && (hc_c < HS_END));
    vs_c     = !((vc_c >= VS_START) && (vc_c < VS_END));
    fs_c     = active_c && (h_cnt == '0) && (v_cnt == '0);
    col_c    = '0;
    row_c    = '0;
    // Subtract only inside the window so no underflow can reach the address
    if (in_win_c) begin
      col_c = COL_W'((hc_c - WIN_X0) >> SCALE_SHIFT);
      row_c = ROW_W'((vc_c - WIN_Y0) >> SCALE_SHIFT);
    end
  end

  // Stage 1: issue the memory read and register the decoded flags
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      rd_en       <= 1'b0;
      rd_col_addr <= '0;
      rd_row_addr <= '0;
      s1_active   <= 1'b0;
      s1_in_win   <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_fs       <= 1'b0;
    end else if (!en) begin
      rd_en       <= 1'b0;
      s1_active   <= 1'b0;
      s1_in_win   <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_fs       <= 1'b0;
    end else begin
      rd_en       <= in_win_c;
      s1_active   <= active_c;
      s1_in_win   <= in_win_c;
      s1_hs       <= hs_c;
      s1_vs       <= vs_c;
      s1_fs       <= fs_c;
      if (in_win_c) begin
        rd_col_addr <= col_c;
        rd_row_addr <= row_c;
      end
    end
  end

  // Stage 2: carry the flags while the memory returns data
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      s2_active <= 1'b0;
      s2_in_win <= 1'b0;
      s2_hs     <= 1'b1;
      s2_vs     <= 1'b1;
      s2_fs     <= 1'b0;
    end else if (!en) begin
      s2_active <= 1'b0;
      s2_in_win <= 1'b0;
      s2_hs     <= 1'b1;
      s2_vs     <= 1'b1;
      s2_fs     <= 1'b0;
    end else begin
      s2_active <= s1_active;
      s2_in_win <= s1_in_win;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      s2_fs     <= s1_fs;
    end
  end

  // Pixel select: memory inside the window, border elsewhere in active video, black in blanking
  always_comb begin
    px_c = '0;
    if (s2_in_win)      px_c = rd_data;
    else if (s2_active) px_c = border_rgb;
  end

  // Stage 3: output registers
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_de      <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else if (!en) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_de      <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= px_c[11:8];
      vga_g       <= px_c[7:4];
      vga_b       <= px_c[3:0];
      vga_de      <= s2_active;
      vga_hs      <= s2_hs;
      vga_vs      <= s2_vs;
      frame_start <= s2_fs;
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: directed sequence with randomized border colour, checked every cycle
// against a raster-index model of the scanout (pixel index -> expected outputs).
// Timing is shrunk (330x150 total, 2x upscale) so a full frame fits a short run.
module tb_frame_scanout;

  localparam int HA = 300, HF = 8, HSW = 12, HB = 10;
  localparam int VA = 140, VF = 3, VSW = 2, VB = 5;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int SH = 1, WX0 = 20, WY0 = 6;
  localparam int WX1 = WX0 + (128 << SH), WY1 = WY0 + (64 << SH);
  localparam int FRAME = HT * VT;

  logic        vga_clk = 1'b0;
  logic        rst, en;
  logic [11:0] border_rgb;
  logic [11:0] rd_data;
  logic [6:0]  rd_col_addr;
  logic [5:0]  rd_row_addr;
  logic        rd_en;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start;

  int n_cmp = 0, n_err = 0;
  int n = 0;
  int fs_cnt = 0, hs_lo = 0, vs_lo = 0;
  logic [6:0] e_col;
  logic [5:0] e_row;

  frame_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SCALE_SHIFT(SH), .WIN_X0(WX0), .WIN_Y0(WY0)
  ) dut (
    .vga_clk(vga_clk), .rst(rst), .en(en), .border_rgb(border_rgb),
    .rd_col_addr(rd_col_addr), .rd_row_addr(rd_row_addr), .rd_en(rd_en),
    .rd_data(rd_data), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .frame_start(frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  // Frame memory: synchronous read, garbage when not strobed
  always @(posedge vga_clk)
    rd_data <= rd_en ? {rd_col_addr[3:0], rd_row_addr[3:0], 4'hA} : 12'hxxx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return (p >= 0) && h >= WX0 && h < WX1 && v >= WY0 && v < WY1 && h < HA && v < VA;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    chk({tag, "_de"}, vga_de, 1'b0);
    chk({tag, "_hs"}, vga_hs, 1'b1);
    chk({tag, "_vs"}, vga_vs, 1'b1);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_rden"}, rd_en, 1'b0);
    chk({tag, "_col"}, rd_col_addr, 7'd0);
    chk({tag, "_row"}, rd_row_addr, 6'd0);
  endtask

  // One clock: check outputs (pixel n-3) and read port (pixel n-1), then perturb border
  task automatic step();
    int p, h, v, h1, v1;
    logic [11:0] er;
    logic ede, ehs, evs, efs, erd;
    @(posedge vga_clk);
    #1;
    if (en) n++;
    er = 12'h000; ede = 1'b0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
    if (en && n >= 3) begin
      p   = n - 3;
      h   = p % HT;
      v   = (p / HT) % VT;
      ede = (h < HA) && (v < VA);
      ehs = !(h >= HA + HF && h < HA + HF + HSW);
      evs = !(v >= VA + VF && v < VA + VF + VSW);
      efs = (p % FRAME) == 0;
      if (in_win(p))
        er = {4'((h - WX0) >> SH), 4'((v - WY0) >> SH), 4'hA};
      else if (ede)
        er = border_rgb;
      if (p == WY0 * HT + WX0 + 1) chk("first_win", {vga_r, vga_g, vga_b}, 12'h00A);
      if (p == WY0 * HT + WX0 + 2) chk("second_col", {vga_r, vga_g, vga_b}, 12'h10A);
      if (p == (WY1 - 1) * HT + WX1 - 1) chk("last_win", {vga_r, vga_g, vga_b}, 12'hFFA);
      if (p == WY0 * HT + WX0 - 1) chk("bdr_left", {vga_r, vga_g, vga_b}, border_rgb);
      if (p == WY0 * HT + WX1) chk("bdr_right", {vga_r, vga_g, vga_b}, border_rgb);
    end
    chk("rgb", {vga_r, vga_g, vga_b}, er);
    chk("de", vga_de, ede);
    chk("hs", vga_hs, ehs);
    chk("vs", vga_vs, evs);
    chk("fs", frame_start, efs);
    erd = en && in_win(n - 1);
    if (erd) begin
      h1    = (n - 1) % HT;
      v1    = ((n - 1) / HT) % VT;
      e_col = 7'((h1 - WX0) >> SH);
      e_row = 6'((v1 - WY0) >> SH);
    end
    chk("rd_en", rd_en, erd);
    chk("rd_col", rd_col_addr, e_col);
    chk("rd_row", rd_row_addr, e_row);
    if (frame_start) fs_cnt++;
    if (!vga_hs) hs_lo++;
    if (!vga_vs) vs_lo++;
    border_rgb = 12'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    border_rgb = 12'h123;
    e_col = '0;
    e_row = '0;
    repeat (3) @(posedge vga_clk);
    #1;
    chk_reset_vals("por");

    // Run into the window, then reset mid-frame
    rst = 1'b0;
    n = 0;
    repeat (10 * HT + 150 + 3) step();
    rst = 1'b1;
    #1;
    e_col = '0;
    e_row = '0;
    chk_reset_vals("async_rst");
    repeat (3) begin
      @(posedge vga_clk);
      #1;
      chk_reset_vals("rst_hold");
    end
    rst = 1'b0;
    n = 0;

    // One full frame plus the start of the next
    fs_cnt = 0; hs_lo = 0; vs_lo = 0;
    repeat (FRAME + 10) step();
    chk("fs_per_frame", fs_cnt, 2);
    chk("hs_low_cycles", hs_lo, HSW * VT);
    chk("vs_low_cycles", vs_lo, VSW * HT);

    // Drop enable mid-line, then restart from the origin
    en = 1'b0;
    repeat (50) step();
    en = 1'b1;
    n = 0;
    fs_cnt = 0;
    repeat (3 * HT) step();
    chk("fs_after_en", fs_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_scanout.md
Name: frame_scanout

Overview:
- Display-side reader of the 128x64, 12-bit colour frame memory that the tracer host writes pixel by pixel.
- Generates 640x480@60 VGA timing and reads the frame memory through a synchronous read port.
- Upscales each stored pixel to a SCALE x SCALE block inside a fixed window; the rest of the active area shows a border colour.
- Emits a frame-start pulse so the tracer side can align with frame boundaries.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SCALE_SHIFT, 2, log2 of the upscale factor (4x gives a 512x256 window)
WIN_X0, 64, first active column of the window
WIN_Y0, 112, first active line of the window

Ports:
vga_clk  input  1  pixel clock (25 MHz nominal)
rst  input  1  asynchronous reset, active-high
en  input  1  scan enable; low holds the scan at the frame origin, blanked
border_rgb  input  12  colour for active pixels outside the window
rd_col_addr  output  7  frame memory column address
rd_row_addr  output  6  frame memory row address
rd_en  output  1  frame memory read strobe
rd_data  input  12  frame memory data, valid one cycle after rd_en
vga_r  output  4  red = pixel[11:8]
vga_g  output  4  green = pixel[7:4]
vga_b  output  4  blue = pixel[3:0]
vga_hs  output  1  hsync, active-low
vga_vs  output  1  vsync, active-low
vga_de  output  1  active-video flag
frame_start  output  1  one-cycle pulse on the first active pixel of each frame

Behaviour:
- Reset (async, rst=1): every register is cleared.
  - h_cnt=0, v_cnt=0.
  - rd_col_addr=0, rd_row_addr=0, rd_en=0.
  - vga_r/g/b=0, vga_de=0, frame_start=0.
  - vga_hs=1, vga_vs=1 (sync inactive).
  - Reset mid-frame aborts the frame; the scan restarts at h=0, v=0 on the first edge after release.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (800). Wraps to 0.
  - v_cnt increments when h_cnt wraps. It runs 0..V_TOTAL-1 (525), then wraps to 0.
  - Active area is h<H_ACTIVE and v<V_ACTIVE.
  - hsync is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vsync uses the equivalent rule on v.
- en=0: counters are synchronously forced to 0. rd_en=0 and every pipeline stage is loaded with blank, sync-inactive values.
- en rising: the scan starts at h=0, v=0. The first frame_start appears 3 cycles later.
- Pipeline (3 stages, fixed latency 3 from counters to outputs):
  - S1 (registered from counters):
    - in_win = active && WIN_X0 <= h < WIN_X0+(128<<SCALE_SHIFT) && WIN_Y0 <= v < WIN_Y0+(64<<SCALE_SHIFT).
    - rd_en = in_win.
    - rd_col_addr = (h-WIN_X0)>>SCALE_SHIFT; rd_row_addr = (v-WIN_Y0)>>SCALE_SHIFT, both truncated to the port width.
    - Addresses hold their last value when rd_en=0.
  - S2: rd_data is valid; the S1 flags are carried forward.
  - S3 (output registers):
    - rgb = rd_data if in_win, else border_rgb if active, else 0.
    - vga_de = active; vga_hs/vga_vs = delayed sync.
- All sync, de and frame_start signals pass through the same 3-stage delay, so they stay aligned with the rgb outputs.
- frame_start: high for exactly the one cycle whose output pixel is h=0, v=0. It does not fire while en=0.
- Window arithmetic:
  - Subtractions are evaluated only when in_win=1, so no underflow reaches the address.
  - Last window pixel is h=575, v=367, giving col 127, row 63.
- rd_data outside in_win is ignored, including X values.
- border_rgb is sampled at S3 (no latency guarantee relative to changes).

Test Plan:
- Reset then run 1 frame (420000 clocks) -> hs low for 96 clocks per line, starting at output h=656; vs low for lines 490-491; 525 lines per frame; frame_start pulses once per 420000 clocks.
- Memory model returns {col[3:0],row[3:0],4'hA} -> output pixel at h=64..67, v=112 = 0x00A; pixel at h=575, v=367 = 0xF FA; h=63 and h=576 on line 112 = border_rgb (0x123).
- Check rd_en and addresses -> rd_en high only inside the window; col sequence 0,0,0,0,1,... per line; row increments every 4 lines; rd_data ignored (drive X) outside the window with no X on outputs.
- Blanking check -> at h=640..799 and v>=480: vga_de=0, rgb=0 irrespective of border_rgb=0xFFF.
- Assert rst for 3 cycles at h=300, v=200 -> outputs go to reset values immediately; after release, frame_start arrives exactly 3 cycles after the first edge.
- Drop en for 50 cycles mid-frame, then raise it -> blank output with syncs high during en=0; scan restarts at the origin with frame_start 3 cycles after en rises.
